branch_ctrl: RTL
================

Name: branch_ctrl

Overview:
- Decode-stage branch controller that sequences the equality comparator used for beq/bne resolution in the pipelined MIPS core.
- Holds the branch in ID (stall) until both comparator operands are forwarded-ready, then resolves taken/not-taken and drives the next-PC redirect.
- Tracks stall cycles and flags a sticky error when a wait exceeds the legal hazard depth.
- Maintains branch performance counters for the bench and debug.

Parameters:
- CNT_W, 32, width of the performance counters.
- MAX_WAIT, 2, maximum legal consecutive operand-wait cycles for one branch (load-to-branch worst case).
- WAIT_W, 2, width of the wait counter; must hold MAX_WAIT+1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- br_valid  in  1  ID holds a beq/bne
- br_ne  in  1  1 = bne, 0 = beq
- rs_ready  in  1  rs operand valid at comparator input (no pending producer)
- rt_ready  in  1  rt operand valid at comparator input
- cmp_eq  in  1  comparator result (A == B)
- br_target  in  32  computed branch target
- id_stall_ext  in  1  ID held by another hazard source this cycle
- id_flush  in  1  ID contents invalid (exception/flush)
- stall_id  out  1  freeze PC/IF/ID, bubble into EX
- npc_sel  out  1  select npc_target for the next fetch
- npc_target  out  32  redirect address
- busy  out  1  FSM in WAIT
- wait_cnt  out  WAIT_W  current consecutive wait cycles
- timeout_err  out  1  sticky: wait exceeded MAX_WAIT
- br_cnt  out  CNT_W  branches resolved
- taken_cnt  out  CNT_W  branches taken
- stall_cnt  out  CNT_W  total branch-induced stall cycles

Behaviour:
- Reset: state=IDLE, wait_cnt=0, timeout_err=0, all counters=0. stall_id, npc_sel and npc_target read 0 during reset.
- Internal signals:
  - ops_ready = rs_ready & rt_ready
  - act = br_valid & ~id_flush
  - resolve = act & ops_ready
  - taken = cmp_eq ^ br_ne
- Combinational outputs (same cycle, zero latency; needed for delay-slot timing):
  - stall_id = act & ~ops_ready
  - npc_sel = resolve & taken
  - npc_target = br_target when npc_sel, else 0
- FSM states: IDLE, WAIT.
  - IDLE -> WAIT when stall_id.
  - WAIT -> IDLE on resolve, ~br_valid, or id_flush.
  - WAIT stays in WAIT while stall_id.
- wait_cnt:
  - Increments each cycle stall_id is high and saturates at MAX_WAIT+1.
  - Cleared on any cycle stall_id is low.
  - When stall_id is high and wait_cnt == MAX_WAIT, timeout_err is set; it stays set until reset.
- Counters (wrap modulo 2^CNT_W):
  - stall_cnt += 1 each cycle stall_id is high.
  - br_cnt += 1 and taken_cnt += taken on resolve & ~id_stall_ext. This counts once per branch even when ID is held externally; redirect outputs remain asserted during the hold (IF is frozen too, so this is harmless).
- Priority: reset > id_flush > resolve > wait. A flush during WAIT returns to IDLE with no count and no redirect.
- Back-to-back branches (the branch leaves ID on the resolve cycle, the next instruction is also a branch) are treated independently. The FSM is in IDLE or leaves WAIT on the resolve cycle, so the new branch starts clean.
- br_valid dropping in WAIT without resolve (should not happen) returns to IDLE silently.

Decomposition:
- Shared package cpu_pkg:
  - branch FSM state encoding (IDLE=0, WAIT=1)
  - BR_EQ/BR_NE opcode constants
  - default CNT_W
- One natural sub-module: br_perf_cnt, a counter bank for br_cnt/taken_cnt/stall_cnt with enable inputs.
- FSM, wait counter and next-PC logic stay in branch_ctrl.

Test Plan:
- beq, both ready, cmp_eq=1, br_target=0x00003010 -> same cycle npc_sel=1, npc_target=0x00003010, stall_id=0; next cycle br_cnt=1, taken_cnt=1.
- bne, ready, cmp_eq=1 -> npc_sel=0, npc_target=0; br_cnt increments, taken_cnt unchanged.
- beq with rt_ready=0 for 2 cycles then 1 -> stall_id=1 for 2 cycles, busy=1, wait_cnt 1->2, resolves on the 3rd cycle; stall_cnt=2, timeout_err=0.
- rs_ready held 0 for 3 cycles -> timeout_err rises after the 3rd stall cycle and stays 1 after ready returns and after later branches.
- WAIT, then id_flush=1 -> stall_id=0, npc_sel=0, next state IDLE, br_cnt unchanged. Separately, resolve with id_stall_ext=1 for 3 cycles then 0 -> br_cnt +1 exactly once.
- Assert reset mid-WAIT with counters nonzero -> next cycle all counters 0, wait_cnt=0, busy=0, timeout_err=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core decode-stage control blocks.
package cpu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } br_state_e;

  localparam logic BR_EQ = 1'b0;
  localparam logic BR_NE = 1'b1;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/br_perf_cnt.sv
// Branch performance counter bank: resolved, taken and stall-cycle counts.
// Registered, one-cycle update; wraps modulo 2^CNT_W; no backpressure.
module br_perf_cnt
  import cpu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_en,
  input  logic             taken_en,
  input  logic             stall_en,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    br_cnt_d    = br_cnt_q    + (br_en    ? CNT_W'(1) : '0);
    taken_cnt_d = taken_cnt_q + (taken_en ? CNT_W'(1) : '0);
    stall_cnt_d = stall_cnt_q + (stall_en ? CNT_W'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/branch_ctrl.sv
// Decode-stage beq/bne controller: stalls ID until operands are ready, then redirects.
// Redirect/stall are combinational (zero latency); status and counters update next cycle.
module branch_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_WAIT = 2,
  parameter int WAIT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic              br_ne,
  input  logic              rs_ready,
  input  logic              rt_ready,
  input  logic              cmp_eq,
  input  logic [31:0]       br_target,
  input  logic              id_stall_ext,
  input  logic              id_flush,
  output logic              stall_id,
  output logic              npc_sel,
  output logic [31:0]       npc_target,
  output logic              busy,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic ops_ready, act, resolve, taken;
  br_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  // Reset gates act so the redirect/stall outputs read 0 while reset is held.
  always_comb begin
    ops_ready  = rs_ready & rt_ready;
    act        = br_valid & ~id_flush & ~reset;
    resolve    = act & ops_ready;
    taken      = cmp_eq ^ (br_ne == BR_NE);
    stall_id   = act & ~ops_ready;
    npc_sel    = resolve & taken;
    npc_target = npc_sel ? br_target : '0;
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    timeout_err_d = timeout_err_q | (stall_id & (wait_cnt_q == WAIT_LIM));
    case (state_q)
      ST_IDLE: if (stall_id)  state_d = ST_WAIT;
      ST_WAIT: if (!stall_id) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (stall_id) begin
      wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign busy        = (state_q == ST_WAIT);
  assign wait_cnt    = wait_cnt_q;
  assign timeout_err = timeout_err_q;

  // An externally held ID keeps resolve high; count only the cycle it moves on.
  br_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .reset     (reset),
    .br_en     (resolve & ~id_stall_ext),
    .taken_en  (resolve & ~id_stall_ext & taken),
    .stall_en  (stall_id),
    .br_cnt    (br_cnt),
    .taken_cnt (taken_cnt),
    .stall_cnt (stall_cnt)
  );

endmodule
